game_mode_ctrl: RTL and testbench
=================================

// Module: game_mode_ctrl
// PURPOSE
//  Game-state controller that produces the game_mode (START/GAME/PLAYER1_WIN/PLAYER2_WIN)
//  consumed by the screen multiplexer in the draw path. It tracks button presses and player
//  death events, and requests a map re-initialisation on every new round.
//  The visible mode changes only on a frame boundary, so a screen switch never tears mid-frame.
// PARAMETERS
//  WIN_HOLD_FRAMES  180  frames a win screen is held before btn_start is accepted (3 s @60 Hz)
// PORTS
//  clk          in   1          pixel/system clock; everything is on posedge clk
//  rst          in   1          synchronous, active-high reset
//  btn_start    in   1          debounced start/restart button level (1 = pressed)
//  p1_dead      in   1          1-cycle pulse: player 1 eliminated
//  p2_dead      in   1          1-cycle pulse: player 2 eliminated
//  frame_tick   in   1          1-cycle pulse at start of vertical blanking, once per frame
//  mode         out  game_mode  frame-aligned mode to the draw path (game_pkg enum)
//  map_init     out  1          1-cycle pulse: reload map to its initial layout
// BEHAVIOUR
//  Reset:
//  - state_q = START, mode = START, map_init = 0, hold_cnt = 0.
//  - btn_q = 1, so a button held through reset does not count as a press.
//  Press detection:
//  - press = btn_start & ~btn_q; btn_q <= btn_start every cycle.
//  - A button held continuously yields exactly one press.
//  State machine (state_q, updates on the cycle after the event):
//  - START: press -> GAME; assert map_init for exactly 1 cycle (the cycle state_q becomes GAME).
//  - GAME:
//    - p1_dead only -> PLAYER2_WIN.
//    - p2_dead only -> PLAYER1_WIN.
//    - p1_dead and p2_dead in the same cycle -> START (draw, no winner).
//    - presses ignored.
//  - PLAYERx_WIN:
//    - hold_cnt clears to 0 on entry; +1 on each frame_tick; saturates at WIN_HOLD_FRAMES.
//    - Width is $clog2(WIN_HOLD_FRAMES+1).
//    - press while hold_cnt < WIN_HOLD_FRAMES: ignored.
//    - press with hold_cnt == WIN_HOLD_FRAMES -> START.
//  - Death pulses outside GAME are ignored.
//  - Invalid or unused state encoding -> START.
//  Output alignment:
//  - mode <= state_q only on cycles where frame_tick=1; otherwise mode holds.
//  - Latency: an event in cycle n reaches state_q at n+1 and mode on the first frame_tick
//    at or after n+1, visible one cycle later.
//  - An event coinciding with frame_tick (state_q still old) shows one frame later.
//  - Several transitions within one frame: mode shows only the last state_q at the tick;
//    intermediate states are never displayed.
//  - map_init is not frame-aligned; the map is reloaded while START is still on screen.
//  - Reset asserted mid-operation: all registers return to reset values the next cycle;
//    no map_init pulse is generated.
// TESTING
//  1) Reset with btn_start=1 held, then release and press
//     -> no transition while held; 1 press -> state GAME, one map_init pulse.
//  2) In GAME, p2_dead pulse at cycle n, frame_tick at n+50
//     -> mode stays GAME until n+50, becomes PLAYER1_WIN at n+51.
//  3) WIN_HOLD_FRAMES=4: press after 3 frame_ticks
//     -> ignored; press after 4 ticks -> START on the next tick, and no map_init.
//  4) p1_dead and p2_dead in the same cycle in GAME -> START, mode START after the next tick.
//  5) START->GAME then p1_dead within one frame -> mode goes START -> PLAYER2_WIN directly.
//  6) Reset pulse while in PLAYER1_WIN with hold_cnt=2
//     -> mode=START and hold_cnt=0 on the following cycle; map_init=0.

Source files
------------

// File: rtl/game_mode_ctrl_if.sv
// Game mode type shared with the draw path, plus the controller's signal bundle.
// Inputs come from the button/game logic; outputs go to the screen multiplexer.
package game_pkg;
  typedef enum logic [1:0] {
    START       = 2'd0,
    GAME        = 2'd1,
    PLAYER1_WIN = 2'd2,
    PLAYER2_WIN = 2'd3
  } game_mode;
endpackage

interface game_mode_ctrl_if;
  import game_pkg::*;

  logic     btn_start;   // debounced start button level
  logic     p1_dead;     // player 1 eliminated pulse
  logic     p2_dead;     // player 2 eliminated pulse
  logic     frame_tick;  // start of vertical blanking pulse
  game_mode mode;        // frame-aligned mode
  logic     map_init;    // map reload pulse

  // Stimulus / consumer side
  modport master (
    output btn_start, p1_dead, p2_dead, frame_tick,
    input  mode, map_init
  );

  // Controller side
  modport slave (
    input  btn_start, p1_dead, p2_dead, frame_tick,
    output mode, map_init
  );
endinterface

// File: rtl/game_mode_ctrl.sv
// Game-state controller: tracks presses and deaths, requests a map reload on
// every new round, and publishes the mode only on frame boundaries so the
// screen never switches mid-frame.
module game_mode_ctrl
  import game_pkg::*;
#(
  parameter int WIN_HOLD_FRAMES = 180
) (
  input  logic              clk,
  input  logic              rst,
  game_mode_ctrl_if.slave   bus
);

  localparam int             CW       = $clog2(WIN_HOLD_FRAMES + 1);
  localparam logic [CW-1:0]  HOLD_MAX = CW'(WIN_HOLD_FRAMES);

  game_mode          state_q;
  game_mode          state_next;
  game_mode          mode_q;
  logic              btn_q;
  logic              press;
  logic              map_init_q;
  logic              map_init_next;
  logic [CW-1:0]     hold_cnt;
  logic [CW-1:0]     hold_next;

  // Rising edge of the button level; btn_q resets high so a held button is not a press
  assign press = bus.btn_start & ~btn_q;

  // Next-state and map reload request
  always_comb begin
    state_next    = state_q;
    map_init_next = 1'b0;
    case (state_q)
      START: begin
        if (press) begin
          state_next    = GAME;
          map_init_next = 1'b1;
        end
      end
      GAME: begin
        if (bus.p1_dead && bus.p2_dead) begin
          state_next = START;          // simultaneous elimination is a draw
        end else if (bus.p1_dead) begin
          state_next = PLAYER2_WIN;
        end else if (bus.p2_dead) begin
          state_next = PLAYER1_WIN;
        end
      end
      PLAYER1_WIN, PLAYER2_WIN: begin
        if (press && (hold_cnt == HOLD_MAX)) begin
          state_next = START;
        end
      end
      default: state_next = START;
    endcase
  end

  // Win-screen hold counter: zero outside the win states, so it is clear on entry
  always_comb begin
    hold_next = '0;
    if ((state_q == PLAYER1_WIN) || (state_q == PLAYER2_WIN)) begin
      hold_next = hold_cnt;
      if (bus.frame_tick && (hold_cnt != HOLD_MAX)) begin
        hold_next = hold_cnt + CW'(1);
      end
    end
  end

  // State, button history, counter and frame-aligned mode registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= START;
      mode_q     <= START;
      map_init_q <= 1'b0;
      hold_cnt   <= '0;
      btn_q      <= 1'b1;
    end else begin
      state_q    <= state_next;
      map_init_q <= map_init_next;
      hold_cnt   <= hold_next;
      btn_q      <= bus.btn_start;
      if (bus.frame_tick) begin
        mode_q <= state_q;             // old state: an event on the tick shows next frame
      end
    end
  end

  assign bus.mode     = mode_q;
  assign bus.map_init = map_init_q;

endmodule

// File: tb/tb_game_mode_ctrl.sv
// Bench for game_mode_ctrl: directed scenarios with literal expectations, then
// randomized traffic, all checked every cycle against a behavioural model.
module tb_game_mode_ctrl;
  import game_pkg::*;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  // Behavioural model: 0=START 1=GAME 2=PLAYER1_WIN 3=PLAYER2_WIN
  int   m_state;
  int   m_mode;
  int   m_map;
  int   m_hold;
  int   m_btn;

  game_mode_ctrl_if gif();

  game_mode_ctrl #(.WIN_HOLD_FRAMES(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (gif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance the model by one clock with the inputs that the DUT sampled
  task automatic model_step(input int r, input int b, input int d1, input int d2, input int t);
    int press;
    int nxt;
    if (r != 0) begin
      m_state = 0; m_mode = 0; m_map = 0; m_hold = 0; m_btn = 1;
      return;
    end
    press = (b != 0 && m_btn == 0) ? 1 : 0;
    nxt   = m_state;
    m_map = 0;
    if (m_state == 0 && press == 1) begin
      nxt = 1; m_map = 1;
    end else if (m_state == 1) begin
      if (d1 != 0 && d2 != 0) nxt = 0;
      else if (d1 != 0)       nxt = 3;
      else if (d2 != 0)       nxt = 2;
    end else if (m_state >= 2) begin
      if (press == 1 && m_hold == W) nxt = 0;
    end
    // Counter counts ticks spent in a win state; it starts over on every entry
    if (m_state >= 2) begin
      if (t != 0 && m_hold < W) m_hold = m_hold + 1;
    end else begin
      m_hold = 0;
    end
    if (t != 0) m_mode = m_state;
    m_btn   = b;
    m_state = nxt;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive inputs, let the edge happen, update model, compare at negedge
  task automatic step(input int r, input int b, input int d1, input int d2, input int t);
    rst            = (r != 0);
    gif.btn_start  = (b != 0);
    gif.p1_dead    = (d1 != 0);
    gif.p2_dead    = (d2 != 0);
    gif.frame_tick = (t != 0);
    @(posedge clk);
    model_step(r, b, d1, d2, t);
    @(negedge clk);
    check("mode", int'(gif.mode), m_mode);
    check("map_init", int'(gif.map_init), m_map);
  endtask

  task automatic idle(input int n, input int b);
    for (int i = 0; i < n; i++) step(0, b, 0, 0, 0);
  endtask

  initial begin
    int btn;
    checks = 0; errors = 0;
    m_state = 0; m_mode = 0; m_map = 0; m_hold = 0; m_btn = 1;
    rst = 1'b1; gif.btn_start = 1'b1; gif.p1_dead = 1'b0; gif.p2_dead = 1'b0; gif.frame_tick = 1'b0;
    @(negedge clk);

    // 1) reset with button held, release, press
    for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
    check("reset_mode_lit", int'(gif.mode), 0);
    check("reset_map_lit", int'(gif.map_init), 0);
    idle(3, 1);
    step(0, 1, 0, 0, 1);
    check("held_no_start_lit", int'(gif.mode), 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    $display("txn press_from_start map_init=%0d", gif.map_init);
    check("start_map_pulse_lit", int'(gif.map_init), 1);
    step(0, 1, 0, 0, 0);
    check("map_pulse_one_cycle_lit", int'(gif.map_init), 0);
    step(0, 1, 0, 0, 1);
    check("mode_game_lit", int'(gif.mode), 1);

    // 2) p2_dead at n, tick at n+50
    step(0, 1, 0, 1, 0);
    idle(49, 1);
    check("mode_still_game_lit", int'(gif.mode), 1);
    step(0, 1, 0, 0, 1);
    $display("txn p2_dead_then_tick mode=%0d", gif.mode);
    check("mode_p1_win_lit", int'(gif.mode), 2);

    // 3) hold: one tick already counted; two more -> 3, press ignored
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    check("early_press_ignored_lit", int'(gif.mode), 2);
    step(0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0);
    check("win_exit_no_map_lit", int'(gif.map_init), 0);
    step(0, 1, 0, 0, 1);
    $display("txn press_after_hold mode=%0d", gif.mode);
    check("win_to_start_lit", int'(gif.mode), 0);

    // 4) draw
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 1, 1, 0);
    step(0, 1, 0, 0, 1);
    $display("txn draw mode=%0d", gif.mode);
    check("draw_to_start_lit", int'(gif.mode), 0);

    // 5) START->GAME->PLAYER2_WIN within one frame
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    idle(3, 1);
    step(0, 1, 1, 0, 0);
    step(0, 1, 0, 0, 1);
    $display("txn fast_round mode=%0d", gif.mode);
    check("skip_game_lit", int'(gif.mode), 3);

    // 6) reset during PLAYER1_WIN with hold=2
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 1, 0);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    check("pre_reset_p1_win_lit", int'(gif.mode), 2);
    step(1, 1, 0, 0, 0);
    $display("txn reset_in_win mode=%0d map_init=%0d", gif.mode, gif.map_init);
    check("reset_mid_mode_lit", int'(gif.mode), 0);
    check("reset_mid_map_lit", int'(gif.map_init), 0);

    // Randomized traffic against the model
    btn = 1;
    for (int i = 0; i < 4000; i++) begin
      int r, d1, d2, t;
      if ($urandom_range(0, 5) == 0) btn = 1 - btn;
      r  = ($urandom_range(0, 299) == 0) ? 1 : 0;
      d1 = ($urandom_range(0, 29) == 0) ? 1 : 0;
      d2 = ($urandom_range(0, 29) == 0) ? 1 : 0;
      t  = ($urandom_range(0, 7) == 0) ? 1 : 0;
      step(r, btn, d1, d2, t);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
